// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared constants and types for the SPI register target:
//                register address map, frame geometry and FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Register address map seen by the off-chip SPI controller
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Frame geometry: R/W bit, 7-bit address, 8-bit data
    localparam int FRAME_BITS = 16;

    // Bit counter stops here so an over-long frame can never wrap back to 16
    localparam logic [4:0] BIT_CNT_SAT = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

    // Address field of a received frame
    function automatic logic [6:0] frame_addr(input logic [15:0] frame);
        return frame[14:8];
    endfunction

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for one asynchronous input, with
//                optional rise/fall detection on the synchronized level.
//  Ports       : clk, rst_n   - system clock, async active-low reset
//                i_d          - asynchronous input pin
//                o_level      - synchronized level
//                o_rise/o_fall- one-clk pulses on synchronized edges
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0,
    parameter bit   EDGE_DET    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Reset preloads the idle level so leaving reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic r_prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev <= RST_VAL;
                end else begin
                    r_prev <= o_level;
                end
            end

            assign o_rise =  o_level & ~r_prev;
            assign o_fall = ~o_level &  r_prev;
        end else begin : g_level_only
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : spi_peripheral
//  Description : Write-only SPI mode-0 target. Receives 16-bit frames
//                (R/W, 7-bit address, 8-bit data, MSB first) oversampled in
//                the clk domain and writes five 8-bit control registers.
//  Ports       : clk, rst_n          - system clock, async active-low reset
//                sclk, copi, ncs     - asynchronous SPI pins
//                en_reg_out_7_0 .. pwm_duty_cycle - registers at addr 0..4
//                wr_strobe           - one-clk pulse when a write commits
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam logic [6:0] c_max_addr = 7'(MAX_ADDR);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic w_sclk_level, w_sclk_rise, w_sclk_fall_unused;
    logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
    logic w_copi_level, w_copi_rise_unused, w_copi_fall_unused;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0),
        .EDGE_DET    (1'b1)
    ) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall_unused)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1),
        .EDGE_DET    (1'b1)
    ) u_sync_ncs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (ncs),
        .o_level (w_ncs_level),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    // COPI is only sampled as a level; it travels the same number of
    // stages as SCLK so data set up before the SCLK rise stays aligned.
    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0),
        .EDGE_DET    (1'b0)
    ) u_sync_copi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (copi),
        .o_level (w_copi_level),
        .o_rise  (w_copi_rise_unused),
        .o_fall  (w_copi_fall_unused)
    );

    // sclk level itself is not needed beyond its edge detector
    logic w_sclk_level_unused;
    assign w_sclk_level_unused = w_sclk_level;

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    spi_state_t r_state;
    spi_state_t w_state_next;

    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic        w_frame_ok;
    logic        w_shift_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ncs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_ncs_rise) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A frame commits only if it is exactly one full frame, a write, and
    // targets an implemented address.
    assign w_frame_ok = (r_bit_cnt == 5'(FRAME_BITS))
                      && r_shift[15]
                      && (frame_addr(r_shift) <= c_max_addr);

    always_comb begin
        wr_strobe  = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            SHIFT:   w_shift_en = w_sclk_rise && !w_ncs_level;
            COMMIT:  wr_strobe  = w_frame_ok;
            default: begin
                wr_strobe  = 1'b0;
                w_shift_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == IDLE && w_ncs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[14:0], w_copi_level};
            if (r_bit_cnt != BIT_CNT_SAT) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers: only ever written in COMMIT, so each output
    // changes in a single clean step.
    // ------------------------------------------------------------------
    logic [7:0] r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out_lo <= 8'h00;
            r_en_out_hi <= 8'h00;
            r_en_pwm_lo <= 8'h00;
            r_en_pwm_hi <= 8'h00;
            r_duty      <= 8'h00;
        end else if (wr_strobe) begin
            case (frame_addr(r_shift))
                ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[7:0];
                ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[7:0];
                ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[7:0];
                ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[7:0];
                ADDR_DUTY:      r_duty      <= r_shift[7:0];
                default:        ;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;

endmodule : spi_peripheral
`default_nettype wire

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI target (mode 0, write-only) that receives 16-bit frames from an off-chip SPI controller and writes the five 8-bit control registers read by pwm_peripheral: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. Sits in the top-level wrapper between ui_in[2:0] (SCLK, COPI, nCS) and the pwm_peripheral register inputs. All SPI pins are asynchronous to clk and are oversampled in the system clock domain.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2).
MAX_ADDR, 4, highest valid register address; writes above this are dropped.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from controller (ui_in[0]), async
copi  input  1  SPI data from controller (ui_in[1]), async
ncs  input  1  SPI chip select, active low (ui_in[2]), async
en_reg_out_7_0  output  8  register addr 0x00
en_reg_out_15_8  output  8  register addr 0x01
en_reg_pwm_7_0  output  8  register addr 0x02
en_reg_pwm_15_8  output  8  register addr 0x03
pwm_duty_cycle  output  8  register addr 0x04
wr_strobe  output  1  one-clk pulse when a register write commits

Behaviour:
- Reset (rst_n low, async): all five registers = 8'h00, wr_strobe = 0, synchronizers preset to idle levels (sclk=0, copi=0, ncs=1), shift reg = 0, bit count = 0, FSM = IDLE.
- Synchronizers: SYNC_STAGES flops per input, plus one extra flop on sclk and ncs for edge detection. Rising/falling edges are detected only on synchronized values.
- Frame format, MSB first: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data. COPI is sampled on synchronized SCLK rising edges only.
- Timing requirement on the controller: SCLK high and low phases each ≥ 3 clk periods; nCS setup/hold to SCLK ≥ 3 clk periods.
- FSM:
  - IDLE: on ncs falling edge, clear shift reg and bit count, go to SHIFT.
  - SHIFT: on each sclk rising edge while ncs is low, shift copi into the LSB and increment the 5-bit bit count, saturating at 17. On ncs rising edge, go to COMMIT.
  - COMMIT (one cycle): write when count == 16, bit15 == 1 and address ≤ MAX_ADDR. A write updates the addressed register with data and pulses wr_strobe for exactly this cycle. Always returns to IDLE.
- Dropped frames: fewer than 16 bits, more than 16 bits, bit15 == 0 (read), or address > MAX_ADDR. A dropped frame leaves all registers unchanged and gives no wr_strobe.
- Latency: the register value changes on the clk edge SYNC_STAGES+2 cycles after nCS rises at the pin (4 cycles at default). The new value then holds until the next valid write or reset.
- SCLK edges while nCS is high are ignored; COPI is don't-care.
- nCS falling while already in SHIFT (glitch) is impossible without a rising edge first. An ncs rise and fall within the same synchronized sample is invisible and is treated as a continuous frame.
- Reset mid-frame aborts the frame. After release the FSM waits in IDLE for the next nCS falling edge; a partial frame never commits.
- Writes to the same address back to back: the last write wins. Registers are only ever written in COMMIT, so outputs are glitch-free to pwm_peripheral.

Decomposition:
- Shared package spi_reg_pkg: address constants ADDR_EN_OUT_LO=7'h00, ADDR_EN_OUT_HI=7'h01, ADDR_EN_PWM_LO=7'h02, ADDR_EN_PWM_HI=7'h03, ADDR_DUTY=7'h04; FRAME_BITS=16; FSM state enum {IDLE, SHIFT, COMMIT}.
- One sub-module: sync_edge_det (SYNC_STAGES-flop synchronizer with rise/fall outputs and a reset-value parameter), instantiated for sclk, ncs, and copi (copi uses level only).

Test Plan:
- Reset check: hold rst_n low, toggle sclk/copi -> all five regs 8'h00, wr_strobe never asserts.
- Valid write: frame 16'h80F0 (write, addr 0, data F0) -> en_reg_out_7_0 = 8'hF0 exactly 4 clk after nCS rises, one wr_strobe pulse, other regs 00. Repeat for addr 1-4 with 8'hCC, 8'h55, 8'hAA, 8'h80 -> each lands in the correct register only.
- Read and bad address: frames 16'h0412 (read) and 16'h8533 (addr 5) -> no register change, no wr_strobe.
- Wrong length: 15-bit frame 16'h80FF truncated and 17-bit frame -> registers unchanged, no wr_strobe; a following valid 16'h84 80 -> pwm_duty_cycle = 8'h80.
- Reset mid-frame: assert rst_n after 8 bits of 16'h8311, release, finish clocking the remaining 8 bits and raise nCS -> en_reg_pwm_15_8 stays 00; the next full 16'h8311 -> 8'h11.
- Back-to-back frames at minimum SCLK phase (3 clk): 16'h8401 then 16'h8402 with 3 clk nCS high between -> pwm_duty_cycle ends at 8'h02, two wr_strobe pulses.
